// File: rtl/sap_controller.sv
// SAP CPU controller: one-hot T1..T6 ring counter, halt flag and control-word decode.
// Optional JMP instruction (opcode 4'b0011) enabled by defining SAP_JMP_EN.
module sap_controller #(
  parameter logic [3:0] OP_LDA = 4'b0000,
  parameter logic [3:0] OP_ADD = 4'b0001,
  parameter logic [3:0] OP_SUB = 4'b0010,
  parameter logic [3:0] OP_OUT = 4'b1110,
  parameter logic [3:0] OP_HLT = 4'b1111
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] opcode,
  output logic       pc_inc,
  output logic       pc_out,
  output logic       pc_load,
  output logic       mar_load,
  output logic       ram_out,
  output logic       ir_load,
  output logic       ir_out,
  output logic       a_load,
  output logic       a_out,
  output logic       alu_sub,
  output logic       alu_out,
  output logic       b_load,
  output logic       out_load,
  output logic [5:0] tstate,
  output logic       halted
);

`ifdef SAP_JMP_EN
  localparam logic [3:0] OP_JMP = 4'b0011;
`endif

  typedef enum logic [5:0] {
    T1 = 6'b000001,
    T2 = 6'b000010,
    T3 = 6'b000100,
    T4 = 6'b001000,
    T5 = 6'b010000,
    T6 = 6'b100000
  } tstate_e;

  tstate_e state;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= T1;
      halted <= 1'b0;
    end else if (!halted) begin
      // HLT freezes the ring at T4 instead of advancing
      if (state == T4 && opcode == OP_HLT) begin
        halted <= 1'b1;
      end else begin
        case (state)
          T1:      state <= T2;
          T2:      state <= T3;
          T3:      state <= T4;
          T4:      state <= T5;
          T5:      state <= T6;
          default: state <= T1;
        endcase
      end
    end
  end

  assign tstate = state;

  always_comb begin
    pc_inc   = 1'b0;
    pc_out   = 1'b0;
    pc_load  = 1'b0;
    mar_load = 1'b0;
    ram_out  = 1'b0;
    ir_load  = 1'b0;
    ir_out   = 1'b0;
    a_load   = 1'b0;
    a_out    = 1'b0;
    alu_sub  = 1'b0;
    alu_out  = 1'b0;
    b_load   = 1'b0;
    out_load = 1'b0;
    if (!halted) begin
      case (state)
        T1: begin
          pc_out   = 1'b1;
          mar_load = 1'b1;
        end
        T2: pc_inc = 1'b1;
        T3: begin
          ram_out = 1'b1;
          ir_load = 1'b1;
        end
        T4: begin
          if (opcode == OP_LDA || opcode == OP_ADD || opcode == OP_SUB) begin
            ir_out   = 1'b1;
            mar_load = 1'b1;
          end else if (opcode == OP_OUT) begin
            a_out    = 1'b1;
            out_load = 1'b1;
          end
`ifdef SAP_JMP_EN
          else if (opcode == OP_JMP) begin
            ir_out  = 1'b1;
            pc_load = 1'b1;
          end
`endif
        end
        T5: begin
          if (opcode == OP_LDA) begin
            ram_out = 1'b1;
            a_load  = 1'b1;
          end else if (opcode == OP_ADD || opcode == OP_SUB) begin
            ram_out = 1'b1;
            b_load  = 1'b1;
            alu_sub = (opcode == OP_SUB);
          end
        end
        T6: begin
          if (opcode == OP_ADD || opcode == OP_SUB) begin
            alu_out = 1'b1;
            a_load  = 1'b1;
            alu_sub = (opcode == OP_SUB);
          end
        end
        default: ;
      endcase
    end
  end

endmodule
